jtcontra_mainio: RTL and testbench

Parametrised main-CPU I/O controller for the Contra-family cores. It replaces the single-register sound latch, bank register and IRQ flip-flop glue with a depth-configurable sound-command FIFO that has an IRQ/ack handshake, a watchdog, coin-counter registers, a wider bank register and a readable status byte. It sits between the 6809 bus decoder (which supplies `io_cs`) and the sound CPU and ROM banking logic.

---
 rtl/jtcontra_mainio.sv | 153 +++++++++++++++
 tb/tb_jtcontra_mainio.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_mainio.sv
// Main-CPU I/O block for Contra-family cores: sound-command FIFO with IRQ/ack
// handshake, watchdog, coin counters, ROM bank register and status readback.
module jtcontra_mainio #(
    parameter int BANKW     = 4,
    parameter int SND_DEPTH = 4,
    parameter int WDOG_W    = 16,
    parameter int WDOG_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_cen,
    input  logic             io_cs,
    input  logic [2:0]       addr,
    input  logic             rnw,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic [BANKW-1:0] bank,
    output logic [1:0]       coin_cnt,
    output logic [7:0]       snd_latch,
    output logic             snd_irq,
    input  logic             snd_ack,
    input  logic             gfx_irqn,
    input  logic             irq_ack,
    output logic             irq_n,
    output logic             wdog_rst
);
    localparam int PW = $clog2(SND_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, GAP} snd_state_t;

    snd_state_t     state, state_nx;
    logic           we, rd_stat, push, do_push, pop, full, empty;
    logic [7:0]     mem [SND_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [3:0]     cnt4;
    logic           ovf;
    logic [7:0]     last_pop;
    logic           gfx_last, pending;

    assign we      = cpu_cen & io_cs & ~rnw;
    assign rd_stat = cpu_cen & io_cs & rnw & (addr == 3'd7);
    assign push    = we & (addr == 3'd2);
    assign full    = count == CW'(SND_DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign pop     = (state == REQ) & snd_ack;
    assign cnt4    = 4'(count);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            last_pop <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr];
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & full) ovf <= 1'b1;
            else if (rd_stat) ovf <= 1'b0;
        end
    end

    assign snd_latch = empty ? last_pop : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // GAP heads straight back to REQ when more data waits, so back-to-back
    // commands see exactly one low clk on snd_irq.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = REQ;
            REQ:     if (snd_ack) state_nx = GAP;
            GAP:     state_nx = empty ? IDLE : REQ;
            default: state_nx = IDLE;
        endcase
    end

    assign snd_irq = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            bank     <= '0;
            coin_cnt <= '0;
        end else if (we) begin
            if (addr == 3'd0) coin_cnt <= din[1:0];
            if (addr == 3'd4) bank     <= din[BANKW-1:0];
        end
    end

    always_comb begin
        dout = '1;
        if (io_cs & rnw) begin
            case (addr)
                3'd4:    dout = 8'(bank);
                3'd7:    dout = {full, empty, ovf, 1'b0, cnt4};
                default: dout = '1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gfx_last <= 1'b1;
            pending  <= 1'b0;
        end else begin
            gfx_last <= gfx_irqn;
            if (gfx_last & ~gfx_irqn) pending <= 1'b1;
            else if (irq_ack)         pending <= 1'b0;
        end
    end

    assign irq_n = ~pending;

    generate
        if (WDOG_EN != 0) begin : g_wdog
            logic [WDOG_W-1:0] wcnt;
            logic              kick;
            assign kick = we & (addr == 3'd3);
            // The pulse marks the increment that lands on all-ones; the next tick wraps.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wcnt     <= '0;
                    wdog_rst <= 1'b0;
                end else begin
                    wdog_rst <= cpu_cen & ~kick & (wcnt == ~(WDOG_W'(1)));
                    if (kick)         wcnt <= '0;
                    else if (cpu_cen) wcnt <= wcnt + 1'b1;
                end
            end
        end else begin : g_nowdog
            assign wdog_rst = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_jtcontra_mainio.sv
// Self-checking bench for jtcontra_mainio: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_jtcontra_mainio;
    localparam int DEPTH = 4;
    localparam int WW    = 4;

    logic       clk = 0, rst;
    logic       cpu_cen, io_cs, rnw, snd_ack, gfx_irqn, irq_ack;
    logic [2:0] addr;
    logic [7:0] din, dout, snd_latch;
    logic [3:0] bank;
    logic [1:0] coin_cnt;
    logic       snd_irq, irq_n, wdog_rst;

    int n_tests = 0, n_fail = 0;

    jtcontra_mainio #(.BANKW(4), .SND_DEPTH(DEPTH), .WDOG_W(WW), .WDOG_EN(1)) dut (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .io_cs(io_cs), .addr(addr),
        .rnw(rnw), .din(din), .dout(dout), .bank(bank), .coin_cnt(coin_cnt),
        .snd_latch(snd_latch), .snd_irq(snd_irq), .snd_ack(snd_ack),
        .gfx_irqn(gfx_irqn), .irq_ack(irq_ack), .irq_n(irq_n), .wdog_rst(wdog_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending commands plus simple per-rule state.
    logic [7:0] q[$];
    logic [7:0] m_last;
    logic [3:0] m_bank;
    logic [1:0] m_coin;
    bit m_ovf, m_req, m_pend, m_prevg, m_wdog, valid = 0;
    int m_ticks;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_last = 0; m_bank = 0; m_coin = 0;
            m_ovf = 0; m_req = 0; m_pend = 0; m_prevg = 1; m_wdog = 0; m_ticks = 0;
            valid = 1;
        end else begin
            bit ne, fl, w, kick;
            ne   = q.size() != 0;
            fl   = q.size() == DEPTH;
            w    = cpu_cen && io_cs && !rnw;
            kick = w && addr == 3;
            if (m_req && snd_ack) begin
                m_last = q.pop_front();
                m_req  = 0;
            end else if (!m_req && ne) begin
                m_req = 1;
            end
            if (cpu_cen && io_cs && rnw && addr == 7) m_ovf = 0;
            if (w && addr == 2) begin
                if (fl) m_ovf = 1;
                else    q.push_back(din);
            end
            if (w && addr == 0) m_coin = din[1:0];
            if (w && addr == 4) m_bank = din[3:0];
            if (m_prevg && !gfx_irqn) m_pend = 1;
            else if (irq_ack)         m_pend = 0;
            m_prevg = gfx_irqn;
            m_wdog = 0;
            if (kick) m_ticks = 0;
            else if (cpu_cen) begin
                m_ticks++;
                if (m_ticks % (1 << WW) == (1 << WW) - 1) m_wdog = 1;
            end
        end
    end

    function automatic logic [7:0] exp_dout();
        logic [3:0] c;
        c = 4'(q.size());
        if (!(io_cs && rnw)) return 8'hFF;
        case (addr)
            3'd4:    return {4'b0, m_bank};
            3'd7:    return {q.size() == DEPTH, q.size() == 0, m_ovf, 1'b0, c};
            default: return 8'hFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            chk("m_snd_irq", snd_irq, m_req);
            chk("m_snd_latch", snd_latch, q.size() != 0 ? q[0] : m_last);
            chk("m_irq_n", irq_n, !m_pend);
            chk("m_wdog_rst", wdog_rst, m_wdog);
            chk("m_bank", bank, m_bank);
            chk("m_coin", coin_cnt, m_coin);
            chk("m_dout", dout, exp_dout());
        end
    end

    task automatic step();
        @(posedge clk); #1;
        cpu_cen = 0; io_cs = 0; rnw = 1; addr = 0; din = 0; snd_ack = 0; irq_ack = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cpu_cen = 1; io_cs = 1; rnw = 0; addr = a; din = d;
        step();
    endtask

    task automatic rd(input logic [2:0] a, input logic cen, input string nm, input logic [7:0] exp);
        cpu_cen = cen; io_cs = 1; rnw = 1; addr = a;
        @(negedge clk);
        chk(nm, dout, exp);
        step();
    endtask

    task automatic wait_irq();
        for (int i = 0; i < 10 && !snd_irq; i++) step();
        chk("wait_snd_irq", snd_irq, 1);
    endtask

    initial begin
        rst = 1; gfx_irqn = 1;
        cpu_cen = 0; io_cs = 0; rnw = 1; addr = 0; din = 0; snd_ack = 0; irq_ack = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        @(negedge clk);
        chk("rst_irq_n", irq_n, 1);
        chk("rst_snd_irq", snd_irq, 0);
        rd(7, 1, "rst_status", 8'h40);

        // Two commands with handshake
        wr(2, 8'h12);
        @(negedge clk);
        chk("latency_irq_low", snd_irq, 0);
        wr(2, 8'h34);
        @(negedge clk);
        chk("cmd1_irq", snd_irq, 1);
        chk("cmd1_latch", snd_latch, 8'h12);
        snd_ack = 1; step();
        @(negedge clk);
        chk("gap_irq", snd_irq, 0);
        step();
        @(negedge clk);
        chk("cmd2_irq", snd_irq, 1);
        chk("cmd2_latch", snd_latch, 8'h34);
        snd_ack = 1; step();
        step(); step();
        rd(7, 1, "drained_status", 8'h40);
        chk("drained_latch", snd_latch, 8'h34);

        // Overflow
        for (int i = 0; i < 5; i++) wr(2, 8'hA0 + 8'(i));
        rd(7, 1, "ovf_status", 8'hA4);
        rd(7, 1, "ovf_cleared", 8'h84);
        for (int i = 0; i < 4; i++) begin
            wait_irq();
            chk("ovf_drain_latch", snd_latch, 8'hA0 + 8'(i));
            snd_ack = 1; step();
        end
        repeat (3) step();
        chk("ovf_fifth_lost", snd_irq, 0);

        // Push and pop in the same clk
        wr(2, 8'h55); wr(2, 8'h66);
        wait_irq();
        chk("sim_head", snd_latch, 8'h55);
        cpu_cen = 1; io_cs = 1; rnw = 0; addr = 2; din = 8'h77; snd_ack = 1;
        step();
        @(negedge clk);
        chk("sim_latch", snd_latch, 8'h66);
        rd(7, 0, "sim_count", 8'h02);
        wait_irq(); chk("sim_next1", snd_latch, 8'h66); snd_ack = 1; step();
        wait_irq(); chk("sim_next2", snd_latch, 8'h77); snd_ack = 1; step();

        // CPU IRQ set/ack
        gfx_irqn = 0; step();
        @(negedge clk); chk("irq_set", irq_n, 0);
        gfx_irqn = 1; step(); step();
        gfx_irqn = 0; irq_ack = 1; step();
        @(negedge clk); chk("irq_set_wins", irq_n, 0);
        irq_ack = 1; step();
        @(negedge clk); chk("irq_acked", irq_n, 1);
        gfx_irqn = 1; step();

        // Bank, coin counters, unmapped read
        wr(4, 8'hFF);
        @(negedge clk); chk("bank_val", bank, 4'hF);
        rd(4, 0, "bank_read", 8'h0F);
        wr(0, 8'h03);
        @(negedge clk); chk("coin_val", coin_cnt, 2'b11);
        rd(0, 0, "unmapped_read", 8'hFF);

        // Reset mid-operation
        wr(2, 8'h9A); wr(2, 8'hBC);
        rst = 1; step(); rst = 0;
        @(negedge clk);
        chk("midrst_irq", snd_irq, 0);
        chk("midrst_latch", snd_latch, 8'h00);
        chk("midrst_bank", bank, 4'h0);
        rd(7, 0, "midrst_status", 8'h40);

        // Watchdog
        for (int i = 1; i <= 15; i++) begin
            cpu_cen = 1; step();
            @(negedge clk); chk("wdog_first", wdog_rst, i == 15);
        end
        for (int i = 1; i <= 16; i++) begin
            cpu_cen = 1; step();
            @(negedge clk); chk("wdog_second", wdog_rst, i == 16);
        end
        for (int i = 1; i <= 13; i++) begin cpu_cen = 1; step(); end
        wr(3, 8'h00);
        for (int i = 1; i <= 15; i++) begin
            cpu_cen = 1; step();
            @(negedge clk); chk("wdog_kicked", wdog_rst, i == 15);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
